// File: rtl/config_pkg.sv
// config_pkg: core configuration record, PMA rule layout
// and the reset-time rule table builder.
package config_pkg;

  localparam int unsigned MaxRules = 16;

  localparam int unsigned AttrEn      = 0;
  localparam int unsigned AttrCached  = 1;
  localparam int unsigned AttrExec    = 2;
  localparam int unsigned AttrNonIdem = 3;
  localparam int unsigned AttrLock    = 7;
  localparam logic [7:0]  AttrMask    = 8'h8F;

  typedef struct packed {
    int unsigned       NrExecuteRegionRules;
    logic [15:0][63:0] ExecuteRegionAddrBase;
    logic [15:0][63:0] ExecuteRegionLength;
    int unsigned       NrCachedRegionRules;
    logic [15:0][63:0] CachedRegionAddrBase;
    logic [15:0][63:0] CachedRegionLength;
  } cva6_cfg_t;

  typedef struct packed {
    logic [63:0] base;
    logic [63:0] length;
    logic [7:0]  attr;
  } pma_rule_t;

  typedef pma_rule_t [MaxRules-1:0] pma_table_t;

  function automatic logic in_cached(
    cva6_cfg_t cfg, logic [63:0] b, logic [63:0] l
  );
    logic r;
    r = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (c < int'(cfg.NrCachedRegionRules) &&
          b >= cfg.CachedRegionAddrBase[c[3:0]] &&
          b + l <= cfg.CachedRegionAddrBase[c[3:0]] +
                   cfg.CachedRegionLength[c[3:0]])
        r = 1'b1;
    end
    return r;
  endfunction

  function automatic pma_table_t default_table(cva6_cfg_t cfg);
    pma_table_t t;
    t = '0;
    for (int k = 0; k < int'(MaxRules); k++) begin
      if (k < int'(cfg.NrExecuteRegionRules)) begin
        t[k[3:0]].base   = cfg.ExecuteRegionAddrBase[k[3:0]];
        t[k[3:0]].length = cfg.ExecuteRegionLength[k[3:0]];
        t[k[3:0]].attr[AttrEn]   = 1'b1;
        t[k[3:0]].attr[AttrExec] = 1'b1;
        t[k[3:0]].attr[AttrCached] =
          in_cached(cfg, t[k[3:0]].base, t[k[3:0]].length);
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/cva6_config_pkg.sv
// cva6_config_pkg: default core configuration
// (DRAM, boot ROM and debug execute regions).
package cva6_config_pkg;

  import config_pkg::*;

  localparam cva6_cfg_t cva6_cfg = '{
    NrExecuteRegionRules:  3,
    ExecuteRegionAddrBase: {832'd0, 64'h0,
                            64'h1_0000, 64'h8000_0000},
    ExecuteRegionLength:   {832'd0, 64'h1000,
                            64'h1_0000, 64'h4000_0000},
    NrCachedRegionRules:   1,
    CachedRegionAddrBase:  {960'd0, 64'h8000_0000},
    CachedRegionLength:    {960'd0, 64'h4000_0000}
  };

endpackage

// File: rtl/pma_rule_match.sv
// pma_rule_match: combinational compare of one address
// against one base/length rule.
module pma_rule_match #(
  parameter int unsigned AddrW = 34
) (
  input  logic [AddrW-1:0] addr_i,
  input  logic [AddrW-1:0] base_i,
  input  logic [AddrW-1:0] len_i,
  input  logic             en_i,
  output logic             match_o
);

  logic [AddrW-1:0] off;

  assign off     = addr_i - base_i;
  assign match_o = en_i && (addr_i >= base_i) && (off < len_i);

endmodule

// File: rtl/pma_region_table.sv
// pma_region_table: programmable PMA rule table with a
// config port and a one-cycle registered lookup pipe.
module pma_region_table
  import config_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg = cva6_config_pkg::cva6_cfg,
  parameter int unsigned NrRules = 4,
  parameter int unsigned AddrW   = 34
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cfg_req_i,
  input  logic             cfg_we_i,
  input  logic [3:0]       cfg_idx_i,
  input  logic [1:0]       cfg_field_i,
  input  logic [63:0]      cfg_wdata_i,
  output logic             cfg_gnt_o,
  output logic             cfg_rvalid_o,
  output logic [63:0]      cfg_rdata_o,
  output logic             cfg_err_o,
  input  logic             lk_valid_i,
  output logic             lk_ready_o,
  input  logic [AddrW-1:0] lk_addr_i,
  output logic             lk_valid_o,
  input  logic             lk_ready_i,
  output logic             lk_hit_o,
  output logic             lk_cached_o,
  output logic             lk_exec_o,
  output logic             lk_nonidem_o
);

  localparam pma_table_t Def = default_table(CVA6Cfg);

  logic [AddrW-1:0] base_q [MaxRules];
  logic [AddrW-1:0] len_q  [MaxRules];
  logic [7:0]       attr_q [MaxRules];

  logic [MaxRules-1:0] match;

  for (genvar k = 0; k < MaxRules; k++) begin : g_rule
    if (k < NrRules) begin : g_on
      pma_rule_match #(.AddrW(AddrW)) u_match (
        .addr_i  (lk_addr_i),
        .base_i  (base_q[k]),
        .len_i   (len_q[k]),
        .en_i    (attr_q[k][AttrEn]),
        .match_o (match[k])
      );
    end else begin : g_off
      assign match[k] = 1'b0;
    end
  end

  logic hit_d, cached_d, exec_d, nonidem_d;

  // lowest matching slot wins; a miss is uncached I/O
  always_comb begin
    hit_d     = 1'b0;
    cached_d  = 1'b0;
    exec_d    = 1'b0;
    nonidem_d = 1'b1;
    for (int k = int'(MaxRules) - 1; k >= 0; k--) begin
      if (match[k[3:0]]) begin
        hit_d     = 1'b1;
        cached_d  = attr_q[k[3:0]][AttrCached];
        exec_d    = attr_q[k[3:0]][AttrExec];
        nonidem_d = attr_q[k[3:0]][AttrNonIdem];
      end
    end
  end

  logic        idx_ok, cfg_err, cfg_wr;
  logic [63:0] rd_val;
  logic        unused_wdata;

  assign unused_wdata = ^cfg_wdata_i;
  assign idx_ok  = 32'(cfg_idx_i) < NrRules;
  assign cfg_err = !idx_ok || (cfg_field_i == 2'd3) ||
                   (cfg_we_i && attr_q[cfg_idx_i][AttrLock]);
  assign cfg_wr  = cfg_req_i && cfg_we_i && !cfg_err;
  assign cfg_gnt_o = cfg_req_i;

  // field read mux, zero-extended to the bus width
  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      cfg_field_i == 2'd0: rd_val = 64'(base_q[cfg_idx_i]);
      cfg_field_i == 2'd1: rd_val = 64'(len_q[cfg_idx_i]);
      cfg_field_i == 2'd2: rd_val = 64'(attr_q[cfg_idx_i]);
      default:             rd_val = '0;
    endcase
  end

  // rule storage: config defaults at reset, then writes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < int'(MaxRules); k++) begin
        if (k < int'(NrRules)) begin
          base_q[k[3:0]] <= Def[k[3:0]].base[AddrW-1:0];
          len_q[k[3:0]]  <= Def[k[3:0]].length[AddrW-1:0];
          attr_q[k[3:0]] <= Def[k[3:0]].attr & AttrMask;
        end else begin
          base_q[k[3:0]] <= '0;
          len_q[k[3:0]]  <= '0;
          attr_q[k[3:0]] <= '0;
        end
      end
    end else if (cfg_wr) begin
      case (cfg_field_i)
        2'd0:    base_q[cfg_idx_i] <= cfg_wdata_i[AddrW-1:0];
        2'd1:    len_q[cfg_idx_i]  <= cfg_wdata_i[AddrW-1:0];
        default: attr_q[cfg_idx_i] <= cfg_wdata_i[7:0] & AttrMask;
      endcase
    end
  end

  logic lk_valid_q, hit_q, cached_q, exec_q, nonidem_q;

  assign lk_ready_o   = !lk_valid_q || lk_ready_i;
  assign lk_valid_o   = lk_valid_q;
  assign lk_hit_o     = hit_q;
  assign lk_cached_o  = cached_q;
  assign lk_exec_o    = exec_q;
  assign lk_nonidem_o = nonidem_q;

  // lookup result stage; fields only load on accept
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lk_valid_q <= 1'b0;
      hit_q      <= 1'b0;
      cached_q   <= 1'b0;
      exec_q     <= 1'b0;
      nonidem_q  <= 1'b0;
    end else if (lk_valid_i && lk_ready_o) begin
      lk_valid_q <= 1'b1;
      hit_q      <= hit_d;
      cached_q   <= cached_d;
      exec_q     <= exec_d;
      nonidem_q  <= nonidem_d;
    end else if (lk_ready_i) begin
      lk_valid_q <= 1'b0;
    end
  end

  logic        cfg_rvalid_q, cfg_err_q;
  logic [63:0] cfg_rdata_q;

  assign cfg_rvalid_o = cfg_rvalid_q;
  assign cfg_err_o    = cfg_err_q;
  assign cfg_rdata_o  = cfg_rdata_q;

  // single-cycle config response for every granted request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_rvalid_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      cfg_rdata_q  <= '0;
    end else begin
      cfg_rvalid_q <= cfg_req_i;
      cfg_err_q    <= cfg_req_i && cfg_err;
      cfg_rdata_q  <= (cfg_req_i && !cfg_err) ? rd_val : '0;
    end
  end

endmodule

// File: tb/tb_pma_region_table.sv
// tb_pma_region_table: directed and random checks of the
// PMA table against a flat array model.
module tb_pma_region_table;

  localparam int NR = 4;
  localparam int AW = 34;
  localparam logic [63:0] AMASK = (64'd1 << AW) - 64'd1;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          cfg_req_i, cfg_we_i;
  logic [3:0]    cfg_idx_i;
  logic [1:0]    cfg_field_i;
  logic [63:0]   cfg_wdata_i;
  logic          cfg_gnt_o, cfg_rvalid_o, cfg_err_o;
  logic [63:0]   cfg_rdata_o;
  logic          lk_valid_i, lk_ready_o, lk_ready_i;
  logic [AW-1:0] lk_addr_i;
  logic          lk_valid_o, lk_hit_o, lk_cached_o;
  logic          lk_exec_o, lk_nonidem_o;

  always #5 clk_i = ~clk_i;

  pma_region_table dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cfg_req_i    (cfg_req_i),
    .cfg_we_i     (cfg_we_i),
    .cfg_idx_i    (cfg_idx_i),
    .cfg_field_i  (cfg_field_i),
    .cfg_wdata_i  (cfg_wdata_i),
    .cfg_gnt_o    (cfg_gnt_o),
    .cfg_rvalid_o (cfg_rvalid_o),
    .cfg_rdata_o  (cfg_rdata_o),
    .cfg_err_o    (cfg_err_o),
    .lk_valid_i   (lk_valid_i),
    .lk_ready_o   (lk_ready_o),
    .lk_addr_i    (lk_addr_i),
    .lk_valid_o   (lk_valid_o),
    .lk_ready_i   (lk_ready_i),
    .lk_hit_o     (lk_hit_o),
    .lk_cached_o  (lk_cached_o),
    .lk_exec_o    (lk_exec_o),
    .lk_nonidem_o (lk_nonidem_o)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [63:0] m_base [16];
  logic [63:0] m_len  [16];
  logic [7:0]  m_attr [16];
  logic        m_lv, m_rv, m_err, m_rdchk;
  logic [3:0]  m_res;
  logic [63:0] m_rd;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] res();
    return {lk_hit_o, lk_cached_o, lk_exec_o, lk_nonidem_o};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_base[i] = '0;
      m_len[i]  = '0;
      m_attr[i] = '0;
    end
    m_base[0] = 64'h8000_0000; m_len[0] = 64'h4000_0000;
    m_attr[0] = 8'h07;
    m_base[1] = 64'h1_0000;    m_len[1] = 64'h1_0000;
    m_attr[1] = 8'h05;
    m_base[2] = 64'h0;         m_len[2] = 64'h1000;
    m_attr[2] = 8'h05;
    m_lv = 1'b0;
  endfunction

  // {hit, cached, exec, nonidem}
  function automatic logic [3:0] ref_lookup(input logic [63:0] a);
    for (int i = 0; i < NR; i++)
      if (m_attr[i][0] && a >= m_base[i] && a - m_base[i] < m_len[i])
        return {1'b1, m_attr[i][1], m_attr[i][2], m_attr[i][3]};
    return 4'b0001;
  endfunction

  function automatic void ref_cfg(input logic we, input int idx,
                                  input int fld, input logic [63:0] wd,
                                  output logic err,
                                  output logic [63:0] rd);
    err = idx >= NR || fld == 3 || (we && m_attr[idx][7]);
    rd  = '0;
    if (!err) begin
      case (fld)
        0:       rd = m_base[idx];
        1:       rd = m_len[idx];
        default: rd = {56'd0, m_attr[idx]};
      endcase
      if (we) begin
        case (fld)
          0:       m_base[idx] = wd & AMASK;
          1:       m_len[idx]  = wd & AMASK;
          default: m_attr[idx] = wd[7:0] & 8'h8F;
        endcase
      end
    end
  endfunction

  task automatic cyc(input logic creq, input logic cwe, input int cidx,
                     input int cfld, input logic [63:0] cwd,
                     input logic lv, input logic [63:0] la,
                     input logic lr);
    logic exp_rdy;
    cfg_req_i   = creq;
    cfg_we_i    = cwe;
    cfg_idx_i   = 4'(cidx);
    cfg_field_i = 2'(cfld);
    cfg_wdata_i = cwd;
    lk_valid_i  = lv;
    lk_addr_i   = la[AW-1:0];
    lk_ready_i  = lr;
    #1;
    exp_rdy = !m_lv || lr;
    chk("lk_ready", 64'(lk_ready_o), 64'(exp_rdy));
    chk("cfg_gnt", 64'(cfg_gnt_o), 64'(creq));
    if (lv && exp_rdy) begin
      m_lv  = 1'b1;
      m_res = ref_lookup(la & AMASK);
    end else if (lr) begin
      m_lv = 1'b0;
    end
    m_rv  = creq;
    m_err = 1'b0;
    m_rd  = '0;
    if (creq) ref_cfg(cwe, cidx, cfld, cwd, m_err, m_rd);
    m_rdchk = creq && (!cwe || m_err);
    @(posedge clk_i);
    #1;
    chk("lk_valid", 64'(lk_valid_o), 64'(m_lv));
    if (m_lv) chk("lk_result", 64'(res()), 64'(m_res));
    chk("cfg_rvalid", 64'(cfg_rvalid_o), 64'(m_rv));
    if (m_rv) chk("cfg_err", 64'(cfg_err_o), 64'(m_err));
    if (m_rdchk) chk("cfg_rdata", cfg_rdata_o, m_rd);
  endtask

  task automatic idle();
    cfg_req_i = 1'b0; cfg_we_i = 1'b0; cfg_idx_i = '0;
    cfg_field_i = '0; cfg_wdata_i = '0;
    lk_valid_i = 1'b0; lk_addr_i = '0; lk_ready_i = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    chk("rst_lk_valid", 64'(lk_valid_o), 64'd0);
    chk("rst_lk_res", 64'(res()), 64'd0);
    chk("rst_rvalid", 64'(cfg_rvalid_o), 64'd0);
    chk("rst_err", 64'(cfg_err_o), 64'd0);
    chk("rst_rdata", cfg_rdata_o, 64'd0);
    rst_ni = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    do_reset();

    // reset defaults
    cyc(0, 0, 0, 0, 0, 1, 64'h8000_0100, 1);
    chk("rst_dram", 64'(res()), 64'(4'b1110));
    cyc(0, 0, 0, 0, 0, 1, 64'h2000_0000, 1);
    chk("rst_miss", 64'(res()), 64'(4'b0001));
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_base0", cfg_rdata_o, 64'h8000_0000);
    cyc(1, 0, 2, 1, 0, 0, 0, 1);
    cyc(1, 0, 1, 2, 0, 0, 0, 1);
    cyc(1, 0, 3, 2, 0, 0, 0, 1);

    // priority
    cyc(1, 1, 3, 0, 64'h8000_0000, 0, 0, 1);
    cyc(1, 1, 3, 1, 64'h1000, 0, 0, 1);
    cyc(1, 1, 3, 2, 64'h09, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 64'h8000_0010, 1);
    chk("prio_slot0", 64'(res()), 64'(4'b1110));
    cyc(1, 1, 0, 2, 64'h00, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 64'h8000_0010, 1);
    chk("prio_slot3", 64'(res()), 64'(4'b1001));

    // backpressure
    do_reset();
    cyc(0, 0, 0, 0, 0, 1, 64'h8000_0100, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 1, 64'h2000_0000, 0);
      chk("bp_ready", 64'(lk_ready_o), 64'd0);
      chk("bp_hold", 64'(res()), 64'(4'b1110));
    end
    cyc(0, 0, 0, 0, 0, 1, 64'h2000_0000, 1);
    chk("bp_rel0", 64'(res()), 64'(4'b0001));
    cyc(0, 0, 0, 0, 0, 1, 64'h1_0000, 1);
    chk("bp_rel1", 64'(res()), 64'(4'b1010));
    cyc(0, 0, 0, 0, 0, 0, 0, 1);

    // lock
    cyc(1, 1, 1, 2, 64'h81, 0, 0, 1);
    cyc(1, 1, 1, 0, 64'h1234, 0, 0, 1);
    chk("lock_err", 64'(cfg_err_o), 64'd1);
    cyc(1, 0, 1, 0, 0, 0, 0, 1);
    chk("lock_base", cfg_rdata_o, 64'h1_0000);
    cyc(1, 1, 1, 2, 64'h01, 0, 0, 1);
    cyc(1, 0, 1, 2, 0, 0, 0, 1);
    do_reset();
    cyc(1, 1, 1, 0, 64'h1234, 0, 0, 1);
    chk("unlock_err", 64'(cfg_err_o), 64'd0);
    cyc(1, 0, 1, 0, 0, 0, 0, 1);
    chk("unlock_base", cfg_rdata_o, 64'h1234);

    // write and lookup in the same cycle
    do_reset();
    cyc(1, 1, 0, 2, 64'h06, 1, 64'h8000_0000, 1);
    chk("sim_old", 64'(res()), 64'(4'b1110));
    cyc(0, 0, 0, 0, 0, 1, 64'h8000_0000, 1);
    chk("sim_new", 64'(res()), 64'(4'b0001));

    // illegal requests
    cyc(1, 0, NR, 0, 0, 0, 0, 1);
    chk("ill_idx_err", 64'(cfg_err_o), 64'd1);
    chk("ill_idx_rd", cfg_rdata_o, 64'd0);
    cyc(1, 0, 0, 3, 0, 0, 0, 1);
    chk("ill_fld_err", 64'(cfg_err_o), 64'd1);
    cyc(1, 1, NR, 0, 64'hdead, 0, 0, 1);
    cyc(1, 1, 15, 1, 64'hbeef, 0, 0, 1);
    cyc(1, 1, 1, 3, 64'hbeef, 0, 0, 1);
    for (int i = 0; i < NR; i++)
      for (int f = 0; f < 3; f++)
        cyc(1, 0, i, f, 0, 0, 0, 1);

    // base truncation to the address width
    cyc(1, 1, 2, 0, 64'hFFFF_FFFF_8000_1000, 0, 0, 1);
    cyc(1, 0, 2, 0, 0, 0, 0, 1);
    chk("trunc", cfg_rdata_o, 64'h3_8000_1000);

    // reset with a lookup and a response in flight
    cfg_req_i = 1'b1; cfg_we_i = 1'b0; cfg_idx_i = 4'd0;
    cfg_field_i = 2'd0; lk_valid_i = 1'b1;
    lk_addr_i = 34'h8000_0100; lk_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    idle();
    chk("mid_pre_lk", 64'(lk_valid_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("mid_lk", 64'(lk_valid_o), 64'd0);
    chk("mid_rv", 64'(cfg_rvalid_o), 64'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    model_reset();
    @(posedge clk_i);
    #1;
    chk("post_lk", 64'(lk_valid_o), 64'd0);
    chk("post_rv", 64'(cfg_rvalid_o), 64'd0);

    // random traffic
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [63:0] wd, la;
      int ci, cf;
      ci = ($urandom_range(0, 7) == 0) ? int'($urandom_range(NR, 15))
                                        : int'($urandom_range(0, NR - 1));
      cf = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
      wd = {$urandom(), $urandom()};
      if (cf == 0)
        wd[33:0] = 34'h8000_0000 + 34'($urandom_range(0, 15) * 32'h1000);
      else if (cf == 1)
        wd[33:0] = 34'($urandom_range(0, 8) * 32'h1000);
      else
        wd[7:0] = 8'($urandom_range(0, 15)) |
                  (($urandom_range(0, 31) == 0) ? 8'h80 : 8'h00);
      if ($urandom_range(0, 1) == 1)
        la = 64'h8000_0000 + 64'($urandom_range(0, 32'h2_0000));
      else
        la = 64'($urandom());
      cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), ci, cf,
          wd, $urandom_range(0, 2) != 0, la, $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pma_region_table.md
PMA_REGION_TABLE -- requirements
Module: pma_region_table

Interface
REQ-001 SHALL have parameter CVA6Cfg, default cva6_config_pkg::cva6_cfg, the source of the reset-time region tables.
REQ-002 SHALL have parameter NrRules, default 4, the number of programmable rule slots, legal range 1..16.
REQ-003 SHALL have parameter AddrW, default 34, the physical address width compared by lookups.
REQ-004 SHALL have port clk_i, input, width 1, the single clock.
REQ-005 SHALL have port rst_ni, input, width 1, the asynchronous active-low reset.
REQ-006 SHALL have ports cfg_req_i in 1, cfg_we_i in 1, cfg_idx_i in 4, cfg_field_i in 2 (0 base, 1 length, 2 attr), cfg_wdata_i in 64, forming the config request.
REQ-007 SHALL have ports cfg_gnt_o out 1, cfg_rvalid_o out 1, cfg_rdata_o out 64, cfg_err_o out 1, forming the config response.
REQ-008 SHALL have ports lk_valid_i in 1, lk_ready_o out 1, lk_addr_i in AddrW, forming the lookup request.
REQ-009 SHALL have ports lk_valid_o out 1, lk_ready_i in 1, lk_hit_o, lk_cached_o, lk_exec_o, lk_nonidem_o out 1 each, forming the lookup result.

Function
REQ-010 SHALL use this attr layout: bit0 enable, bit1 cached, bit2 execute, bit3 non-idempotent, bit7 lock; all other bits read 0.
REQ-011 SHALL match rule k when enable=1 and base <= addr and (addr - base) < length; length 0 never matches.
REQ-012 SHALL resolve multiple matches to the lowest index.
REQ-013 SHALL, on no match, return hit=0, cached=0, exec=0, nonidem=1.
REQ-014 SHALL register lookup results with 1-cycle latency: a request accepted at cycle N is presented at N+1.
REQ-015 SHALL drive lk_ready_o = !lk_valid_o || lk_ready_i.
REQ-016 SHALL hold the result fields stable while lk_valid_o=1 and lk_ready_i=0.
REQ-017 SHALL evaluate a lookup accepted in the same cycle as a table write against the pre-write table; the write takes effect from the next cycle.
REQ-018 SHALL drive cfg_gnt_o = cfg_req_i, with every request granted in its own cycle.
REQ-019 SHALL, for each granted request, assert cfg_rvalid_o for exactly one cycle on the following cycle, with cfg_rdata_o set to the addressed field value, or 0 on error.
REQ-020 SHALL flag cfg_err_o together with cfg_rvalid_o when cfg_idx_i >= NrRules, cfg_field_i = 3, or a write targets a locked slot; the table SHALL be left unchanged in each case.
REQ-021 SHALL accept a write of attr with bit7=1 to an unlocked slot and lock that slot; the lock SHALL be sticky until reset.
REQ-022 SHALL zero-extend base/length reads and truncate base/length writes to AddrW bits.
REQ-023 SHALL accept back-to-back config requests at one per cycle.

Reset
REQ-024 SHALL, on rst_ni low, asynchronously clear lk_valid_o, cfg_rvalid_o, cfg_err_o, cfg_rdata_o, all result fields, and all lock bits.
REQ-025 SHALL reset slot k < min(NrRules, CVA6Cfg.NrExecuteRegionRules) to ExecuteRegion k base/length with enable=1, execute=1, cached=1 if the slot lies wholly inside a CachedRegion rule, nonidem=0.
REQ-026 SHALL reset all remaining slots to zero (disabled).
REQ-027 SHALL, when reset asserts mid-transaction, discard any in-flight lookup or config response with no output pulse after release.

Structure
REQ-028 SHALL place the rule typedef (base, length, attr), the attr bit-position constants, and the function building the default rule table from cva6_cfg_t in config_pkg.
REQ-029 SHALL use one sub-module, pma_rule_match: a combinational single-rule comparator instantiated NrRules times, followed by a priority select in the parent.

Verification
REQ-030 SHALL cover reset defaults: after reset, lookup 0x8000_0100 -> hit=1, cached=1, exec=1, nonidem=0; lookup 0x2000_0000 -> hit=0, nonidem=1.
REQ-031 SHALL cover priority: program slot 3 with base 0x8000_0000, length 0x1000, attr 0x09; lookup 0x8000_0010 returns slot 0 attributes; after disabling slot 0, the same lookup returns cached=0, nonidem=1.
REQ-032 SHALL cover backpressure: hold lk_ready_i=0 for 3 cycles with lk_valid_i=1 -> lk_ready_o=0 and outputs stable; release -> one result per cycle with no loss or duplication.
REQ-033 SHALL cover lock: write attr 0x81 to slot 1, then write base 0x1234 -> cfg_err_o=1 and readback unchanged; reset -> slot 1 writable again.
REQ-034 SHALL cover simultaneous events: write slot 0 enable=0 in the same cycle a lookup of 0x8000_0000 is accepted -> old hit=1 returned; next lookup -> hit=0.
REQ-035 SHALL cover illegal requests: cfg_idx_i=NrRules or cfg_field_i=3 -> rvalid=1, err=1, rdata=0, table unchanged.
